// File: rtl/rr_arb_pkg.sv
// Shared constants, state type and index helpers for the 4-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ        = 4;
  localparam int unsigned IDX_W        = $clog2(N_REQ);
  localparam int unsigned MAX_HOLD_DEF = 15;
  localparam int unsigned HOLD_W_DEF   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Successor index; wraps 3 -> 0 through natural overflow of the narrow width.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return i + IDX_W'(1);
  endfunction

  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arb4_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  gnt_idx,
    input  gnt_vld,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt_idx,
    output gnt_vld,
    output timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first unmasked request found scanning ptr, ptr+1, ... mod N_REQ.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] masked;
  logic [IDX_W-1:0] cand;

  always_comb begin
    masked = req & ~mask;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'(32'(ptr) + i);
      if (!any && masked[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// 4-requester round-robin arbiter with grant hold, release handshake and hold timeout.
// All outputs are registered; one shared picker serves both arbitration paths.
module rr_arb4
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned HOLD_W   = HOLD_W_DEF
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  rr_arb4_if.slave   arb
);

  localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              timeout;
  logic [HOLD_W-1:0] hold_cnt;

  logic [IDX_W-1:0]  pick_ptr;
  logic [N_REQ-1:0]  pick_mask;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              owner_drop;
  logic              expired;
  logic              rel;

  // In GRANT the picker already looks ahead with the post-release pointer and
  // the owner masked, so a handover needs no extra cycle.
  always_comb begin
    pick_ptr  = ptr;
    pick_mask = '0;
    if (state == GRANT) begin
      pick_ptr  = next_idx(gnt_idx);
      pick_mask = idx_onehot(gnt_idx);
    end
  end

  rr_pick u_pick (
    .req  (arb.req),
    .ptr  (pick_ptr),
    .mask (pick_mask),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign owner_drop = !arb.req[gnt_idx];
  assign expired    = TIMEOUT_EN && (hold_cnt == HOLD_LAST);
  assign rel        = (state == GRANT) && (arb.done || owner_drop || expired);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= GRANT;
            gnt_idx  <= pick_idx;
            gnt_vld  <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr      <= next_idx(gnt_idx);
            timeout  <= expired && !arb.done;
            hold_cnt <= '0;
            if (pick_any) begin
              gnt_idx <= pick_idx;
            end else begin
              state   <= IDLE;
              gnt_vld <= 1'b0;
            end
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          gnt_vld <= 1'b0;
        end
      endcase
    end
  end

  assign arb.gnt_idx = gnt_idx;
  assign arb.gnt_vld = gnt_vld;
  assign arb.timeout = timeout;

endmodule

// File: tb/tb_rr_arb4.sv
// Scoreboard bench for rr_arb4: directed scenarios plus random traffic against a
// grant-ownership reference model; a monitor checks every cycle's registered outputs.
module tb_rr_arb4;

  localparam int MAXH = 4;

  typedef struct {
    bit       vld;
    bit [1:0] idx;
    bit       chk_idx;
    bit       to;
    bit [3:0] req_s;
  } exp_t;

  logic clk;
  logic rstn;
  rr_arb4_if arb ();

  rr_arb4 #(.MAX_HOLD(MAXH), .HOLD_W(3)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .arb    (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: owner (-1 = none), rotation pointer, visible cycles held.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_age   = 0;
  int   m_idx   = 0;
  bit   drv_done = 0;

  function automatic int pick(input bit [3:0] r, input int p, input int excl);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = (p + k) % 4;
      if (n != excl && r[n]) return n;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the outputs expected after the next edge.
  task automatic cycle(input bit r, input bit [3:0] req, input bit done);
    exp_t e;
    bit   to;
    @(negedge clk);
    rstn     = r;
    arb.req  = req;
    arb.done = done;
    to = 0;
    e.chk_idx = 0;
    if (!r) begin
      m_owner = -1; m_ptr = 0; m_age = 0; m_idx = 0;
      e.chk_idx = 1;
    end else if (m_owner < 0) begin
      int p;
      p = pick(req, m_ptr, -1);
      if (p >= 0) begin
        m_owner = p; m_age = 1; m_idx = p;
      end
    end else begin
      bit by_to;
      by_to = (MAXH != 0) && (m_age == MAXH);
      if (done || !req[m_owner] || by_to) begin
        int p;
        to    = by_to && !done;
        m_ptr = (m_owner + 1) % 4;
        p     = pick(req, m_ptr, m_owner);
        m_owner = p;
        m_age   = 1;
        if (p >= 0) m_idx = p;
      end else begin
        m_age++;
      end
    end
    e.vld   = (m_owner >= 0);
    e.idx   = 2'(m_idx);
    e.to    = to;
    e.req_s = req;
    if (e.vld) e.chk_idx = 1;
    q.push_back(e);
  endtask

  // Monitor: every edge presents a registered output set; compare against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        logic [3:0] dec;
        e = q.pop_front();
        chk("gnt_vld", int'(arb.gnt_vld), int'(e.vld));
        chk("timeout", int'(arb.timeout), int'(e.to));
        if (e.chk_idx) chk("gnt_idx", int'(arb.gnt_idx), int'(e.idx));
        if (arb.gnt_vld === 1'b1) chk("grant_to_requester", int'(e.req_s[arb.gnt_idx]), 1);
        dec = (arb.gnt_vld === 1'b1) ? (4'b0001 << arb.gnt_idx) : 4'b0000;
        chk("decoded_onehot", int'(!$isunknown({arb.gnt_vld, arb.gnt_idx}) &&
                                   $onehot0(dec) && ((|dec) == arb.gnt_vld)), 1);
      end
    end
  end

  initial begin
    rstn = 0; arb.req = '0; arb.done = 0;

    // Reset held with all requesting, then first grant to idx 0.
    repeat (3) cycle(0, 4'b1111, 0);
    cycle(1, 4'b1111, 0);
    cycle(1, 4'b1111, 0);

    // Single requester 2, then released by done.
    cycle(0, 4'b0000, 0);
    cycle(1, 4'b0100, 0);
    cycle(1, 4'b0100, 0);
    cycle(1, 4'b0100, 1);
    cycle(1, 4'b0000, 0);

    // All requesting, done every third cycle: 0,1,2,3,0 with no gap.
    cycle(0, 4'b0000, 0);
    for (int i = 0; i < 16; i++) cycle(1, 4'b1111, (i % 3) == 2);

    // Hold timeout with 0011, then done coincident with the 4th held cycle.
    cycle(0, 4'b0000, 0);
    repeat (10) cycle(1, 4'b0011, 0);
    cycle(0, 4'b0000, 0);
    cycle(1, 4'b0011, 0);
    repeat (3) cycle(1, 4'b0011, 0);
    cycle(1, 4'b0011, 1);
    cycle(1, 4'b0000, 0);

    // Owner 1 withdraws with 3 still pending, then everything drops.
    cycle(0, 4'b0000, 0);
    cycle(1, 4'b1010, 0);
    cycle(1, 4'b1000, 0);
    cycle(1, 4'b0000, 0);
    cycle(1, 4'b0000, 0);

    // Reset mid-grant to idx 2; pointer returns to 0.
    cycle(0, 4'b0000, 0);
    cycle(1, 4'b0100, 0);
    cycle(1, 4'b0100, 0);
    cycle(0, 4'b0101, 0);
    cycle(1, 4'b0101, 0);
    cycle(1, 4'b0101, 1);

    // Random traffic with persistent requests, occasional done and rare resets.
    begin
      bit [3:0] r;
      r = 4'b0000;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) r = r ^ 4'($urandom_range(0, 15));
        cycle(($urandom_range(0, 79) != 0), r, ($urandom_range(0, 4) == 0));
      end
    end
    cycle(1, 4'b0000, 0);
    drv_done = 1;

    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
